// File: rtl/slot_arbiter_rr.sv
// Round-robin time-slot arbiter: one requester owns the resource for a slice of
// K cycles (or until it drops its request), then priority rotates past it.
module slot_arbiter_rr #(
    parameter  int N   = 4,
    parameter  int W   = 4,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic [W-1:0]   i_slice_len,
    input  logic [N-1:0]   i_req,
    output logic [N-1:0]   o_grant,
    output logic [IDW-1:0] o_grant_id,
    output logic           o_busy,
    output logic [W-1:0]   o_slice_cnt,
    output logic           o_slice_end
);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t         r_state;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_gid;
    logic [N-1:0]   r_grant;
    logic [W-1:0]   r_len;
    logic [W-1:0]   r_cnt;
    logic           r_busy;
    logic           r_slice_end;

    logic [W-1:0]   w_len_in;
    logic [IDW-1:0] w_nxt_ptr;
    logic [IDW-1:0] w_arb_ptr;
    logic [IDW-1:0] w_win;
    logic           w_found;
    logic           w_last;
    logic           w_handover;

    assign w_len_in   = (i_slice_len == '0) ? W'(1) : i_slice_len;
    assign w_last     = (r_cnt == r_len - W'(1));
    assign w_handover = w_last || !i_req[r_gid];
    assign w_nxt_ptr  = (r_gid == IDW'(N-1)) ? '0 : r_gid + IDW'(1);
    // At a handover the search already starts past the outgoing grantee.
    assign w_arb_ptr  = (r_state == S_GRANT) ? w_nxt_ptr : r_ptr;

    // Scan downward so the last hit is the nearest set bit from the pointer.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (i_req[(int'(w_arb_ptr) + i) % N]) begin
                w_found = 1'b1;
                w_win   = IDW'((int'(w_arb_ptr) + i) % N);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_gid       <= '0;
            r_grant     <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_slice_end <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state     <= S_GRANT;
                        r_gid       <= w_win;
                        r_grant     <= N'(1) << w_win;
                        r_len       <= w_len_in;
                        r_cnt       <= '0;
                        r_busy      <= 1'b1;
                        r_slice_end <= (w_len_in == W'(1));
                    end
                end
                S_GRANT: begin
                    if (w_handover) begin
                        r_ptr <= w_nxt_ptr;
                        if (w_found) begin
                            r_gid       <= w_win;
                            r_grant     <= N'(1) << w_win;
                            r_len       <= w_len_in;
                            r_cnt       <= '0;
                            r_slice_end <= (w_len_in == W'(1));
                        end else begin
                            r_state     <= S_IDLE;
                            r_gid       <= '0;
                            r_grant     <= '0;
                            r_cnt       <= '0;
                            r_busy      <= 1'b0;
                            r_slice_end <= 1'b0;
                        end
                    end else begin
                        r_cnt       <= r_cnt + W'(1);
                        r_slice_end <= (r_cnt + W'(1) == r_len - W'(1));
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_grant     = r_grant;
    assign o_grant_id  = r_gid;
    assign o_busy      = r_busy;
    assign o_slice_cnt = r_cnt;
    assign o_slice_end = r_slice_end;

endmodule

// File: tb/tb_slot_arbiter_rr.sv
// Directed and random checks of slot_arbiter_rr against a cycle-level
// behavioural model of the slice/rotation rules.
module tb_slot_arbiter_rr;
    localparam int N   = 4;
    localparam int W   = 4;
    localparam int IDW = 2;

    logic           i_clk = 1'b0;
    logic           i_reset = 1'b0;
    logic [W-1:0]   i_slice_len = '0;
    logic [N-1:0]   i_req = '0;
    logic [N-1:0]   o_grant;
    logic [IDW-1:0] o_grant_id;
    logic           o_busy;
    logic [W-1:0]   o_slice_cnt;
    logic           o_slice_end;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: who holds the resource, for how long, and where the search starts.
    int m_busy = 0, m_who = 0, m_ptr = 0, m_k = 0, m_elapsed = 0;

    logic [3:0] t3_grant [9];
    int         t3_id    [9];

    slot_arbiter_rr #(.N(N), .W(W)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_slice_len(i_slice_len), .i_req(i_req),
        .o_grant(o_grant), .o_grant_id(o_grant_id), .o_busy(o_busy),
        .o_slice_cnt(o_slice_cnt), .o_slice_end(o_slice_end)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step();
        int found;
        if (!i_reset) begin
            m_busy = 0; m_who = 0; m_ptr = 0; m_k = 0; m_elapsed = 0;
        end else if (m_busy && m_elapsed < m_k - 1 && i_req[m_who]) begin
            m_elapsed++;
        end else begin
            if (m_busy) m_ptr = (m_who + 1) % N;
            found = 0;
            for (int i = 0; i < N; i++)
                if (!found && i_req[(m_ptr + i) % N]) begin
                    found = 1;
                    m_who = (m_ptr + i) % N;
                end
            m_busy    = found;
            m_k       = (i_slice_len == 0) ? 1 : int'(i_slice_len);
            m_elapsed = 0;
            if (!found) m_who = 0;
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".grant"}, int'(o_grant),     m_busy ? (1 << m_who) : 0);
        chk({tag, ".id"},    int'(o_grant_id),  m_busy ? m_who : 0);
        chk({tag, ".busy"},  int'(o_busy),      m_busy);
        chk({tag, ".cnt"},   int'(o_slice_cnt), m_busy ? m_elapsed : 0);
        chk({tag, ".end"},   int'(o_slice_end), (m_busy && m_elapsed == m_k - 1) ? 1 : 0);
    endtask

    // One clock: model and DUT see the same inputs, outputs sampled at negedge.
    task automatic cyc(input string tag);
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
        chk_model(tag);
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        cyc("rst");
        i_reset = 1'b1;
    endtask

    initial begin
        t3_grant = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
        t3_id    = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        @(negedge i_clk);

        // Reset held with requests pending: everything stays zero.
        i_req = 4'b1111; i_slice_len = 4'd3; i_reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc("t1");
            chk("t1.grant0", int'(o_grant), 0);
            chk("t1.busy0",  int'(o_busy), 0);
        end

        // Full rotation, two cycles each.
        i_reset = 1'b1; i_slice_len = 4'd2;
        for (int i = 0; i < 9; i++) begin
            cyc("t3");
            chk("t3.grant_tbl", int'(o_grant), int'(t3_grant[i]));
            chk("t3.id_tbl",    int'(o_grant_id), t3_id[i]);
        end

        // Sole requester: continuous grant, counter wraps every 3.
        i_req = 4'b0001; i_slice_len = 4'd3;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cyc("t2");
            chk("t2.grant_c", int'(o_grant), 1);
            chk("t2.cnt_c",   int'(o_slice_cnt), i % 3);
            chk("t2.end_c",   int'(o_slice_end), (i % 3 == 2) ? 1 : 0);
        end

        // Early release by requester 0 at cnt==1.
        i_req = 4'b0011; i_slice_len = 4'd4;
        do_reset();
        cyc("t4a");
        cyc("t4b");
        chk("t4.cnt1", int'(o_slice_cnt), 1);
        chk("t4.noend", int'(o_slice_end), 0);
        i_req = 4'b0010;
        cyc("t4c");
        chk("t4.handover", int'(o_grant), 2);
        chk("t4.cnt0", int'(o_slice_cnt), 0);

        // Zero length acts as one-cycle slices.
        i_req = 4'b0101; i_slice_len = 4'd0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc("t5");
            chk("t5.grant_c", int'(o_grant), (i % 2 == 0) ? 1 : 4);
            chk("t5.end_c",   int'(o_slice_end), 1);
        end

        // Reset mid-slice, pointer returns to 0.
        i_req = 4'b1111; i_slice_len = 4'd4;
        do_reset();
        for (int i = 0; i < 11; i++) cyc("t6");
        chk("t6.pre_grant", int'(o_grant), 4);
        chk("t6.pre_cnt",   int'(o_slice_cnt), 2);
        i_reset = 1'b0;
        cyc("t6r");
        chk("t6.rst_grant", int'(o_grant), 0);
        chk("t6.rst_cnt",   int'(o_slice_cnt), 0);
        i_reset = 1'b1;
        cyc("t6p");
        chk("t6.post_grant", int'(o_grant), 1);

        // Random traffic, length changes and occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3, 0) == 0) i_req = N'($urandom);
            if ($urandom_range(7, 0) == 0) i_slice_len = W'($urandom);
            i_reset = ($urandom_range(63, 0) == 0) ? 1'b0 : 1'b1;
            cyc("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
